// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
//   Shared core-wide constants and the reorder-buffer entry layout.
//   XLEN / REG_ADDR_W   : datapath and architectural register address widths
//   ROB_DEPTH/ROB_TAG_W : default reorder-buffer size and tag width
//   rob_entry_t         : one reorder-buffer entry (busy, done, regwrite, rd, data)
//   rf_write_en()       : register-file write enable with x0 suppression
// ----------------------------------------------------------------------------
package cpu_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int ROB_DEPTH  = 16;
   localparam int ROB_TAG_W  = 4;

   // Entry field widths.
   localparam int ROB_RD_W   = REG_ADDR_W;
   localparam int ROB_DATA_W = XLEN;

   typedef struct packed {
      logic                  busy;
      logic                  done;
      logic                  regwrite;
      logic [ROB_RD_W-1:0]   rd;
      logic [ROB_DATA_W-1:0] data;
   } rob_entry_t;

   // x0 is hard-wired to zero, so writes to it never reach the register file.
   function automatic logic rf_write_en(input logic                  valid,
                                        input logic                  regwrite,
                                        input logic [ROB_RD_W-1:0]   rd);
      return valid && regwrite && (rd != '0);
   endfunction

endpackage

// File: rtl/reorder_buffer.sv
// ----------------------------------------------------------------------------
// reorder_buffer
//   In-order retirement buffer for the 2-wide out-of-order core. Accepts up to
//   two dispatches per cycle in program order, records out-of-order
//   completions, and retires up to two completed instructions per cycle in
//   order, directly driving the register file's two write ports.
//
//   Ports
//     clk, reset                      : clock, synchronous active-high reset
//     alloc0_*/alloc1_*               : dispatch requests (slot 1 only with slot 0)
//     alloc_ready                     : at least two free entries
//     alloc0_tag/alloc1_tag           : tags granted this cycle (tail, tail+1)
//     cmp0_*/cmp1_*                   : completion strobes, tag and result
//     flush                           : discard every entry
//     retire1_valid/retire2_valid     : instructions retiring this cycle
//     rd1/rd2, rd1_data/rd2_data      : retiring destination and result
//     RegWrite1/RegWrite2             : register-file write enables
//     count, empty, full              : occupancy
//
//   Handshake: dispatch is accepted on a rising edge when alloc_ready and
//   allocN_valid are both high; there is no back-pressure on completions or
//   retirement. Retire outputs are combinational from the head entries and are
//   consumed by the register file on the same edge that advances head.
// ----------------------------------------------------------------------------
module reorder_buffer
   import cpu_pkg::*;
#(
   parameter int DEPTH = ROB_DEPTH,
   parameter int TAG_W = ROB_TAG_W
) (
   input  logic                  clk,
   input  logic                  reset,

   input  logic                  alloc0_valid,
   input  logic                  alloc1_valid,
   input  logic [ROB_RD_W-1:0]   alloc0_rd,
   input  logic [ROB_RD_W-1:0]   alloc1_rd,
   input  logic                  alloc0_regwrite,
   input  logic                  alloc1_regwrite,
   output logic                  alloc_ready,
   output logic [TAG_W-1:0]      alloc0_tag,
   output logic [TAG_W-1:0]      alloc1_tag,

   input  logic                  cmp0_valid,
   input  logic                  cmp1_valid,
   input  logic [TAG_W-1:0]      cmp0_tag,
   input  logic [TAG_W-1:0]      cmp1_tag,
   input  logic [ROB_DATA_W-1:0] cmp0_data,
   input  logic [ROB_DATA_W-1:0] cmp1_data,

   input  logic                  flush,

   output logic                  retire1_valid,
   output logic                  retire2_valid,
   output logic [ROB_RD_W-1:0]   rd1,
   output logic [ROB_RD_W-1:0]   rd2,
   output logic [ROB_DATA_W-1:0] rd1_data,
   output logic [ROB_DATA_W-1:0] rd2_data,
   output logic                  RegWrite1,
   output logic                  RegWrite2,

   output logic [TAG_W:0]        count,
   output logic                  empty,
   output logic                  full
);

   localparam logic [TAG_W:0]   READY_LIMIT = (TAG_W+1)'(DEPTH - 2);
   localparam logic [TAG_W:0]   FULL_COUNT  = (TAG_W+1)'(DEPTH);
   localparam logic [TAG_W-1:0] ONE_TAG     = TAG_W'(1);

   rob_entry_t       ent_q [DEPTH];
   rob_entry_t       ent_d [DEPTH];
   logic [TAG_W-1:0] head_q, head_d;
   logic [TAG_W-1:0] tail_q, tail_d;
   logic [TAG_W:0]   count_q, count_d;

   logic [TAG_W-1:0] head_p1;
   logic [TAG_W-1:0] tail_p1;
   logic             alloc0_fire;
   logic             alloc1_fire;
   logic [1:0]       n_alloc;
   logic [1:0]       n_retire;

   // Pointers wrap naturally through TAG_W-bit arithmetic.
   assign head_p1 = head_q + ONE_TAG;
   assign tail_p1 = tail_q + ONE_TAG;

   // Readiness uses the current count only; same-cycle retires are not
   // credited, which keeps this off the retire-to-dispatch path.
   assign alloc_ready = (count_q <= READY_LIMIT);
   assign alloc0_tag  = tail_q;
   assign alloc1_tag  = tail_p1;

   assign alloc0_fire = alloc_ready && alloc0_valid;
   assign alloc1_fire = alloc0_fire && alloc1_valid;

   // Second slot retires only behind the first, preserving program order.
   assign retire1_valid = ent_q[head_q].busy && ent_q[head_q].done;
   assign retire2_valid = retire1_valid && ent_q[head_p1].busy && ent_q[head_p1].done;

   assign rd1      = retire1_valid ? ent_q[head_q].rd    : '0;
   assign rd2      = retire2_valid ? ent_q[head_p1].rd   : '0;
   assign rd1_data = retire1_valid ? ent_q[head_q].data  : '0;
   assign rd2_data = retire2_valid ? ent_q[head_p1].data : '0;

   assign RegWrite1 = rf_write_en(retire1_valid, ent_q[head_q].regwrite,  ent_q[head_q].rd);
   assign RegWrite2 = rf_write_en(retire2_valid, ent_q[head_p1].regwrite, ent_q[head_p1].rd);

   assign n_alloc  = {1'b0, alloc0_fire}   + {1'b0, alloc1_fire};
   assign n_retire = {1'b0, retire1_valid} + {1'b0, retire2_valid};

   assign count = count_q;
   assign empty = (count_q == '0);
   assign full  = (count_q == FULL_COUNT);

   always_comb begin
      ent_d   = ent_q;
      head_d  = head_q + TAG_W'(n_retire);
      tail_d  = tail_q + TAG_W'(n_alloc);
      count_d = count_q + (TAG_W+1)'(n_alloc) - (TAG_W+1)'(n_retire);

      // Completions: port 1 is applied last so it wins a same-tag collision.
      if (cmp0_valid && ent_q[cmp0_tag].busy) begin
         ent_d[cmp0_tag].done = 1'b1;
         ent_d[cmp0_tag].data = cmp0_data;
      end
      if (cmp1_valid && ent_q[cmp1_tag].busy) begin
         ent_d[cmp1_tag].done = 1'b1;
         ent_d[cmp1_tag].data = cmp1_data;
      end

      if (retire1_valid) begin
         ent_d[head_q].busy = 1'b0;
         ent_d[head_q].done = 1'b0;
      end
      if (retire2_valid) begin
         ent_d[head_p1].busy = 1'b0;
         ent_d[head_p1].done = 1'b0;
      end

      // With at least two free entries the tail slots never alias the
      // retiring head slots, so allocation can be applied last.
      if (alloc0_fire) begin
         ent_d[tail_q].busy     = 1'b1;
         ent_d[tail_q].done     = 1'b0;
         ent_d[tail_q].regwrite = alloc0_regwrite;
         ent_d[tail_q].rd       = alloc0_rd;
         ent_d[tail_q].data     = '0;
      end
      if (alloc1_fire) begin
         ent_d[tail_p1].busy     = 1'b1;
         ent_d[tail_p1].done     = 1'b0;
         ent_d[tail_p1].regwrite = alloc1_regwrite;
         ent_d[tail_p1].rd       = alloc1_rd;
         ent_d[tail_p1].data     = '0;
      end

      if (flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_d[i].busy = 1'b0;
            ent_d[i].done = 1'b0;
         end
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= '0;
         end
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= ent_d[i];
         end
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

endmodule
